// File: rtl/tpu_load_ctrl.sv
// tpu_load_ctrl: captures a 2x2 weight matrix and a 2x2 input matrix from the
// host byte stream, then runs a fixed-length compute/readout window by driving
// en and mmu_cycle toward the MMU feeder. Held weights may be reused so the
// host only needs to resend the input matrix.
module tpu_load_ctrl #(
  parameter int LAST_CYCLE = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       keep_weights,
  output logic [7:0] weight0,
  output logic [7:0] weight1,
  output logic [7:0] weight2,
  output logic [7:0] weight3,
  output logic [7:0] input0,
  output logic [7:0] input1,
  output logic [7:0] input2,
  output logic [7:0] input3,
  output logic       en,
  output logic [2:0] mmu_cycle,
  output logic       busy,
  output logic       load_err
);

  localparam logic [2:0] LAST = 3'(LAST_CYCLE);

  typedef enum logic {LOAD, COMPUTE} state_t;

  state_t     state;
  logic [2:0] ptr;

  // The window is active exactly while en is high, so busy simply mirrors it.
  assign busy = en;

  // Load/compute sequencer: operand capture in LOAD, window counting in COMPUTE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      ptr       <= 3'd0;
      en        <= 1'b0;
      mmu_cycle <= 3'd0;
      load_err  <= 1'b0;
      weight0   <= 8'd0;
      weight1   <= 8'd0;
      weight2   <= 8'd0;
      weight3   <= 8'd0;
      input0    <= 8'd0;
      input1    <= 8'd0;
      input2    <= 8'd0;
      input3    <= 8'd0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            if (ptr == 3'd0 && keep_weights) begin
              // Weight reuse: first byte is input0, skip straight to input1.
              input0 <= in_data;
              ptr    <= 3'd5;
            end else begin
              case (ptr)
                3'd0: weight0 <= in_data;
                3'd1: weight1 <= in_data;
                3'd2: weight2 <= in_data;
                3'd3: weight3 <= in_data;
                3'd4: input0  <= in_data;
                3'd5: input1  <= in_data;
                3'd6: input2  <= in_data;
                default: input3 <= in_data;
              endcase
              if (ptr == 3'd7) begin
                ptr       <= 3'd0;
                state     <= COMPUTE;
                en        <= 1'b1;
                mmu_cycle <= 3'd0;
              end else begin
                ptr <= ptr + 3'd1;
              end
            end
          end
        end
        COMPUTE: begin
          // Operands are frozen during the window; any host byte is dropped.
          if (in_valid) begin
            load_err <= 1'b1;
          end
          if (mmu_cycle == LAST) begin
            en        <= 1'b0;
            mmu_cycle <= 3'd0;
            state     <= LOAD;
          end else begin
            mmu_cycle <= mmu_cycle + 3'd1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_load_ctrl.sv
// Testbench for tpu_load_ctrl: directed scenarios plus a randomized run, all
// checked against a behavioural model of the host loader and compute window.
module tb_tpu_load_ctrl;

  localparam int LC = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       keep_weights;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic       en;
  logic [2:0] mmu_cycle;
  logic       busy;
  logic       load_err;

  int cmp_n  = 0;
  int fail_n = 0;

  tpu_load_ctrl #(.LAST_CYCLE(LC)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .keep_weights(keep_weights),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .input0(input0), .input1(input1), .input2(input2), .input3(input3),
    .en(en), .mmu_cycle(mmu_cycle), .busy(busy), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: 8 byte slots, window position (-1 = no window), sticky error.
  logic [7:0] m_w [4];
  logic [7:0] m_i [4];
  int         m_slot;
  int         m_win;
  logic       m_err;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_w[k] = 8'd0;
      m_i[k] = 8'd0;
    end
    m_slot = 0;
    m_win  = -1;
    m_err  = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d, input logic kw);
    if (m_win >= 0) begin
      if (v) m_err = 1'b1;
      m_win = (m_win == LC) ? -1 : m_win + 1;
    end else if (v) begin
      if (m_slot == 0 && kw) begin
        m_i[0] = d;
        m_slot = 5;
      end else begin
        if (m_slot < 4) m_w[m_slot] = d;
        else            m_i[m_slot-4] = d;
        if (m_slot == 7) begin
          m_slot = 0;
          m_win  = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
  endtask

  function automatic logic [69:0] pack_ref();
    logic [2:0] cyc;
    logic       e;
    e   = (m_win >= 0);
    cyc = e ? 3'(m_win) : 3'd0;
    return {m_w[0], m_w[1], m_w[2], m_w[3], m_i[0], m_i[1], m_i[2], m_i[3],
            e, cyc, e, m_err};
  endfunction

  function automatic logic [69:0] pack_dut();
    return {weight0, weight1, weight2, weight3, input0, input1, input2, input3,
            en, mmu_cycle, busy, load_err};
  endfunction

  // One clock: drive inputs, advance the model on the edge, settle 1ns past it.
  task automatic step(input logic v, input logic [7:0] d, input logic kw);
    in_valid     = v;
    in_data      = d;
    keep_weights = kw;
    @(posedge clk);
    model_edge(v, d, kw);
    #1;
    in_valid     = 1'b0;
    keep_weights = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; keep_weights = 1'b0;
    model_reset();
    #3;
    cmp_n++;
    if (pack_dut() !== 70'd0) begin
      fail_n++;
      $display("FAIL reset_state got %h want %h", pack_dut(), 70'd0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_load();
    for (int b = 1; b <= 8; b++) begin
      step(1'b1, 8'(b), 1'b0);
      cmp_n++;
      if (pack_dut() !== pack_ref()) begin
        fail_n++;
        $display("FAIL full_load byte %0d got %h want %h", b, pack_dut(), pack_ref());
      end
    end
    cmp_n++;
    if ({weight0, weight1, weight2, weight3, input0, input1, input2, input3} !== 64'h01020304_05060708) begin
      fail_n++;
      $display("FAIL full_load operands got %h want %h",
               {weight0, weight1, weight2, weight3, input0, input1, input2, input3}, 64'h01020304_05060708);
    end
    for (int k = 0; k <= LC; k++) begin
      cmp_n++;
      if ({en, mmu_cycle} !== {1'b1, 3'(k)}) begin
        fail_n++;
        $display("FAIL full_load window k=%0d got en=%b cyc=%0d want en=1 cyc=%0d", k, en, mmu_cycle, k);
      end
      step(1'b0, 8'd0, 1'b0);
    end
    cmp_n++;
    if ({en, mmu_cycle, load_err} !== 5'b0_000_0) begin
      fail_n++;
      $display("FAIL full_load window_end got en=%b cyc=%0d err=%b want 0,0,0", en, mmu_cycle, load_err);
    end
  endtask

  task automatic test_weight_reuse();
    step(1'b1, 8'd20, 1'b1);
    step(1'b1, 8'd21, 1'b1);
    step(1'b1, 8'd22, 1'b0);
    cmp_n++;
    if (en !== 1'b0) begin
      fail_n++;
      $display("FAIL reuse early_en got %b want 0", en);
    end
    step(1'b1, 8'd23, 1'b0);
    cmp_n++;
    if ({weight0, weight1, weight2, weight3, input0, input1, input2, input3} !== 64'h01020304_14151617) begin
      fail_n++;
      $display("FAIL reuse operands got %h want %h",
               {weight0, weight1, weight2, weight3, input0, input1, input2, input3}, 64'h01020304_14151617);
    end
    for (int k = 0; k <= LC; k++) begin
      cmp_n++;
      if ({en, mmu_cycle} !== {1'b1, 3'(k)}) begin
        fail_n++;
        $display("FAIL reuse window k=%0d got en=%b cyc=%0d want en=1 cyc=%0d", k, en, mmu_cycle, k);
      end
      step(1'b0, 8'd0, 1'b0);
    end
    cmp_n++;
    if (pack_dut() !== pack_ref()) begin
      fail_n++;
      $display("FAIL reuse end got %h want %h", pack_dut(), pack_ref());
    end
  endtask

  task automatic test_gapped_load();
    for (int b = 0; b < 8; b++) begin
      step(1'b1, 8'(10 + b), 1'b0);
      cmp_n++;
      if (en !== (b == 7)) begin
        fail_n++;
        $display("FAIL gapped en after strobe %0d got %b want %b", b, en, (b == 7));
      end
      if (b != 7) step(1'b0, 8'hFF, 1'b1);
    end
    cmp_n++;
    if ({weight0, weight1, weight2, weight3, input0, input1, input2, input3} !== 64'h0A0B0C0D_0E0F1011) begin
      fail_n++;
      $display("FAIL gapped operands got %h want %h",
               {weight0, weight1, weight2, weight3, input0, input1, input2, input3}, 64'h0A0B0C0D_0E0F1011);
    end
    for (int n = 0; n < 20 && en === 1'b1; n++) step(1'b0, 8'd0, 1'b0);
    cmp_n++;
    if (pack_dut() !== pack_ref()) begin
      fail_n++;
      $display("FAIL gapped end got %h want %h", pack_dut(), pack_ref());
    end
  endtask

  task automatic test_write_during_window();
    for (int b = 0; b < 8; b++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    for (int n = 0; n < 10 && mmu_cycle !== 3'd3; n++) step(1'b0, 8'd0, 1'b0);
    cmp_n++;
    if (mmu_cycle !== 3'd3) begin
      fail_n++;
      $display("FAIL busy_write reach_cycle3 got %0d want 3", mmu_cycle);
    end
    step(1'b1, 8'hAA, 1'b1);
    cmp_n++;
    if (pack_dut() !== pack_ref() || load_err !== 1'b1) begin
      fail_n++;
      $display("FAIL busy_write dropped got %h want %h", pack_dut(), pack_ref());
    end
    for (int n = 0; n < 20 && en === 1'b1; n++) step(1'b0, 8'd0, 1'b0);
    for (int b = 0; b < 8; b++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
    cmp_n++;
    if (pack_dut() !== pack_ref() || load_err !== 1'b1 || en !== 1'b1) begin
      fail_n++;
      $display("FAIL busy_write reload got %h want %h", pack_dut(), pack_ref());
    end
  endtask

  task automatic test_mid_window_reset();
    for (int n = 0; n < 20 && en === 1'b1; n++) step(1'b0, 8'd0, 1'b0);
    for (int b = 0; b < 8; b++) step(1'b1, 8'($urandom_range(1, 255)), 1'b0);
    for (int n = 0; n < 10 && mmu_cycle !== 3'd2; n++) step(1'b0, 8'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    cmp_n++;
    if (pack_dut() !== 70'd0) begin
      fail_n++;
      $display("FAIL mid_reset immediate got %h want %h", pack_dut(), 70'd0);
    end
    #2 rst = 1'b0;
    for (int b = 1; b <= 8; b++) step(1'b1, 8'(b), 1'b0);
    cmp_n++;
    if (pack_dut() !== {64'h01020304_05060708, 1'b1, 3'd0, 1'b1, 1'b0}) begin
      fail_n++;
      $display("FAIL mid_reset reload got %h want %h", pack_dut(), {64'h01020304_05060708, 1'b1, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    guard = 0;
    while (en === 1'b1 && guard < 20) begin
      step(1'b0, 8'd0, 1'b0);
      guard++;
    end
    for (int b = 0; b < 8; b++) begin
      step(1'b1, 8'(8'h40 + b), 1'b0);
      cmp_n++;
      if (pack_dut() !== pack_ref() || en !== (b == 7) || load_err !== 1'b0) begin
        fail_n++;
        $display("FAIL back_to_back byte %0d got %h want %h", b, pack_dut(), pack_ref());
      end
    end
    cmp_n++;
    if ({input0, input1, input2, input3} !== 32'h44454647) begin
      fail_n++;
      $display("FAIL back_to_back inputs got %h want %h", {input0, input1, input2, input3}, 32'h44454647);
    end
  endtask

  task automatic test_random();
    logic       v, kw;
    logic [7:0] d;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      kw = ($urandom_range(0, 3) == 0);
      d  = 8'($urandom_range(0, 255));
      step(v, d, kw);
      cmp_n++;
      if (pack_dut() !== pack_ref()) begin
        fail_n++;
        $display("FAIL random cycle %0d got %h want %h", n, pack_dut(), pack_ref());
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_weight_reuse();
    test_gapped_load();
    test_write_during_window();
    test_mid_window_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end

endmodule
